cpu_ctrl_fsm: RTL

- Instruction sequencer for the 8-bit CPU.
- Drives the program counter through its PC_en / jump_en / next_pc_value interface.
- Fetches each 16-bit instruction as two bytes from the byte-addressed ROM, high byte first, and decodes it.
- Issues one-cycle execute strobes to the register file and ALU; stops on HLT.

---
 rtl/cpu_ctrl_pkg.sv | 43 ++++
 rtl/cpu_ctrl_decode.sv | 36 +++
 rtl/cpu_ctrl_fsm.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the 8-bit CPU instruction sequencer.
package cpu_ctrl_pkg;

  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned BYTE_W  = 8;

  typedef enum logic [2:0] {
    FETCH_HI,
    FETCH_LO,
    DECODE,
    EXECUTE,
    HALT
  } state_t;

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_LDI = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB = 4'h3;
  localparam logic [OP_W-1:0] OP_JMP = 4'h4;
  localparam logic [OP_W-1:0] OP_JZ  = 4'h5;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  // Control word produced by the decoder for one instruction.
  typedef struct packed {
    logic       halt;
    logic       pc_en;
    logic       jump_en;
    logic       reg_we;
    logic [1:0] alu_op;
  } ctrl_t;

  // Jump targets are forced even so the PC stays instruction-aligned.
  function automatic logic [ADDR_W-1:0] jump_target(input logic [INSTR_W-1:0] ins);
    return {ins[ADDR_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational opcode decoder; its control word is registered by cpu_ctrl_fsm.
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  input  logic            zero_flag,
  output ctrl_t           ctrl_c
);

  always_comb begin
    ctrl_c       = '0;
    ctrl_c.pc_en = 1'b1;
    case (opcode)
      OP_LDI: begin
        ctrl_c.reg_we = 1'b1;
        ctrl_c.alu_op = ALU_PASS;
      end
      OP_ADD: begin
        ctrl_c.reg_we = 1'b1;
        ctrl_c.alu_op = ALU_ADD;
      end
      OP_SUB: begin
        ctrl_c.reg_we = 1'b1;
        ctrl_c.alu_op = ALU_SUB;
      end
      OP_JMP: ctrl_c.jump_en = 1'b1;
      OP_JZ:  ctrl_c.jump_en = zero_flag;
      OP_HLT: begin
        ctrl_c.pc_en = 1'b0;
        ctrl_c.halt  = 1'b1;
      end
      default: ;  // OP_NOP and unused opcodes 6-E
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Instruction sequencer: two-byte fetch, decode, one-cycle execute, halt.
// Optional CPU_CTRL_SINGLE_STEP_EN adds a step input that gates each instruction fetch.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
`ifdef CPU_CTRL_SINGLE_STEP_EN
  input  logic              step,
`endif
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_en,
  output logic              jump_en,
  output logic [ADDR_W-1:0] next_pc_value,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_re,
  input  logic [BYTE_W-1:0] rom_data,
  input  logic              rom_valid,
  input  logic              zero_flag,
  output logic [INSTR_W-1:0] instr,
  output logic              reg_we,
  output logic [1:0]        alu_op,
  output logic              halted
);

  state_t               state, state_n;
  logic [INSTR_W-1:0]   instr_n;
  logic [ADDR_W-1:0]    next_pc_value_n;
  logic                 pc_en_n, jump_en_n, reg_we_n, rom_re_n, halted_n;
  logic [1:0]           alu_op_n;
  logic                 go_c;
  ctrl_t                dec_c;

  cpu_ctrl_decode u_decode (
    .opcode    (instr[INSTR_W-1 -: OP_W]),
    .zero_flag (zero_flag),
    .ctrl_c    (dec_c)
  );

`ifdef CPU_CTRL_SINGLE_STEP_EN
  logic step_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) step_q <= 1'b0;
    else      step_q <= step;
  end

  assign go_c = step & ~step_q;
`else
  assign go_c = 1'b1;
`endif

  // The PC only moves in EXECUTE, so the address follows pc directly and holds during stalls.
  assign rom_addr = (state == FETCH_LO) ? ADDR_W'(pc + ADDR_W'(1)) : pc;

  always_comb begin
    state_n         = state;
    instr_n         = instr;
    next_pc_value_n = next_pc_value;
    rom_re_n        = rom_re;
    halted_n        = halted;
    pc_en_n         = 1'b0;
    jump_en_n       = 1'b0;
    reg_we_n        = 1'b0;
    alu_op_n        = ALU_PASS;
    case (state)
      // rom_re low here means the fetch is not yet armed (after reset or awaiting step).
      FETCH_HI: begin
        if (!rom_re) begin
          rom_re_n = go_c;
        end else if (rom_valid) begin
          instr_n[INSTR_W-1 -: BYTE_W] = rom_data;
          state_n = FETCH_LO;
        end
      end
      FETCH_LO: begin
        if (rom_valid) begin
          instr_n[BYTE_W-1:0] = rom_data;
          rom_re_n = 1'b0;
          state_n  = DECODE;
        end
      end
      DECODE: begin
        if (dec_c.halt) begin
          halted_n = 1'b1;
          state_n  = HALT;
        end else begin
          pc_en_n         = dec_c.pc_en;
          jump_en_n       = dec_c.jump_en;
          reg_we_n        = dec_c.reg_we;
          alu_op_n        = dec_c.alu_op;
          next_pc_value_n = jump_target(instr);
          state_n         = EXECUTE;
        end
      end
      EXECUTE: begin
        rom_re_n = go_c;
        state_n  = FETCH_HI;
      end
      HALT: ;
      default: state_n = FETCH_HI;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= FETCH_HI;
      instr         <= '0;
      pc_en         <= 1'b0;
      jump_en       <= 1'b0;
      next_pc_value <= '0;
      rom_re        <= 1'b0;
      reg_we        <= 1'b0;
      alu_op        <= ALU_PASS;
      halted        <= 1'b0;
    end else begin
      state         <= state_n;
      instr         <= instr_n;
      pc_en         <= pc_en_n;
      jump_en       <= jump_en_n;
      next_pc_value <= next_pc_value_n;
      rom_re        <= rom_re_n;
      reg_we        <= reg_we_n;
      alu_op        <= alu_op_n;
      halted        <= halted_n;
    end
  end

endmodule
